// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter fed by a circular transmit FIFO; frames drain
//            back-to-back with configurable data width, parity and stop bits.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int c_baud_tick = CLOCK_FREQ / BAUD_RATE;
    localparam int c_baud_w    = (c_baud_tick > 1) ? $clog2(c_baud_tick) : 1;
    localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w     = $clog2(FIFO_DEPTH + 1);
    localparam int c_idx_w     = $clog2(DATA_BITS);

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_baud_tick - 1);
    localparam logic [c_idx_w-1:0]  c_data_last = c_idx_w'(DATA_BITS - 1);
    localparam logic [c_idx_w-1:0]  c_stop_last = c_idx_w'(STOP_BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [c_baud_w-1:0]    r_baud;
    logic [c_baud_w-1:0]    w_baud_nx;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_idx_w-1:0]     w_idx_nx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_tx;
    logic                   r_busy;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];

    logic                   w_push;
    logic                   w_pop;
    logic                   w_tick;
    logic                   w_line;
    logic                   w_not_empty;

    assign tx_ready    = (r_count != c_full);
    assign w_push      = tx_valid && tx_ready;
    assign w_tick      = (r_baud == c_baud_last);
    assign w_not_empty = (r_count != '0);

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = w_tick ? '0 : r_baud + 1'b1;
        w_idx_nx   = r_idx;
        w_pop      = 1'b0;
        w_line     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                w_idx_nx  = '0;
                if (w_not_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_line = 1'b0;
                if (w_tick) begin
                    w_state_nx = S_DATA;
                    w_idx_nx   = '0;
                end
            end
            S_DATA: begin
                w_line = r_shift[r_idx];
                if (w_tick) begin
                    if (r_idx == c_data_last) begin
                        w_idx_nx   = '0;
                        w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_line = (PARITY == 2) ? ^r_shift : ~^r_shift;
                if (w_tick) begin
                    w_state_nx = S_STOP;
                    w_idx_nx   = '0;
                end
            end
            S_STOP: begin
                // r_idx counts stop bits here; the next frame starts with no idle gap
                if (w_tick) begin
                    if (r_idx == c_stop_last) begin
                        w_idx_nx = '0;
                        if (w_not_empty) begin
                            w_pop      = 1'b1;
                            w_state_nx = S_START;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_idx   <= w_idx_nx;
            r_tx    <= w_line;
            r_busy  <= (r_state != S_IDLE);
            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

endmodule
`default_nettype wire
